// File: rtl/servo_sequencer.sv
// Servo position sequencer: arbitrates two command requesters, then steps the
// servo position code one position per PWM frame toward the accepted target,
// holds it for a settle window, and reports completion.
module servo_sequencer #(
  parameter int STEP_CYCLES   = 2000000,
  parameter int SETTLE_CYCLES = 4000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd0_valid,
  input  logic [2:0] cmd0_pos,
  output logic       cmd0_ready,
  input  logic       cmd1_valid,
  input  logic [2:0] cmd1_pos,
  output logic       cmd1_ready,
  output logic [2:0] value,
  output logic       busy,
  output logic       owner,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYC = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       POS_MAX     = 3'd5;

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       target;
  logic             accept0, accept1, accept;
  logic [2:0]       acc_pos;
  logic             acc_legal;
  logic             step_edge, settle_end;
  logic [2:0]       step_val;

  // One position step: a servo that is off jumps straight to the target,
  // a zero target switches the servo off, otherwise move by one position.
  function automatic logic [2:0] step_value(input logic [2:0] cur, input logic [2:0] tgt);
    if (cur == 3'd0)      return tgt;
    else if (tgt == 3'd0) return 3'd0;
    else if (cur < tgt)   return cur + 3'd1;
    else if (cur > tgt)   return cur - 3'd1;
    else                  return cur;
  endfunction

  // Readiness depends only on state and the high-priority valid, never on pos.
  always_comb begin
    cmd0_ready = !rst && (state == IDLE);
    cmd1_ready = !rst && (state == IDLE) && !cmd0_valid;
    accept0    = cmd0_valid && cmd0_ready;
    accept1    = cmd1_valid && cmd1_ready;
    accept     = accept0 || accept1;
    acc_pos    = accept0 ? cmd0_pos : cmd1_pos;
    acc_legal  = (acc_pos <= POS_MAX);
    step_edge  = (state == MOVE) && (cnt == STEP_LAST);
    settle_end = (state == SETTLE) && (cnt == SETTLE_LAST);
    step_val   = step_value(value, target);
    busy       = (state != IDLE);
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && acc_legal) state_next = MOVE;
      MOVE:    if (step_edge && (step_val == target)) state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Command latch, frame/settle counter, position register and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= 3'd0;
      target <= 3'd0;
      owner  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= settle_end;
      err  <= accept && !acc_legal;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept && acc_legal) begin
            target <= acc_pos;
            owner  <= accept1;
          end
        end
        MOVE: begin
          if (step_edge) begin
            value <= step_val;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_end) cnt <= '0;
          else            cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Scoreboard bench for servo_sequencer with STEP_CYCLES=4, SETTLE_CYCLES=3.
// Stimulus pushes hand-computed expected events (value change, done, err) with
// the cycle they must appear; a monitor pops and compares as the DUT shows them.
module tb_servo_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd0_valid = 1'b0;
  logic [2:0] cmd0_pos = 3'd0;
  logic       cmd0_ready;
  logic       cmd1_valid = 1'b0;
  logic [2:0] cmd1_pos = 3'd0;
  logic       cmd1_ready;
  logic [2:0] value;
  logic       busy, owner, done, err;

  servo_sequencer #(.STEP_CYCLES(4), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .cmd0_valid(cmd0_valid), .cmd0_pos(cmd0_pos), .cmd0_ready(cmd0_ready),
    .cmd1_valid(cmd1_valid), .cmd1_pos(cmd1_pos), .cmd1_ready(cmd1_ready),
    .value(value), .busy(busy), .owner(owner), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  localparam int K_VAL = 0, K_DONE = 1, K_ERR = 2;
  typedef struct {int kind; int data; int own; int cyc;} ev_t;
  ev_t q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;
  logic [2:0] prev_val = 3'd0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int data, input int own, input int c);
    ev_t e;
    e.kind = kind; e.data = data; e.own = own; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input int data, input int own);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0d at cycle %0d, expected none", kind, data, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data != data || e.cyc != cyc ||
          (kind != K_VAL && e.own != own)) begin
        errors++;
        $display("FAIL event: got kind %0d data %0d owner %0d cycle %0d, expected kind %0d data %0d owner %0d cycle %0d",
                 kind, data, own, cyc, e.kind, e.data, e.own, e.cyc);
      end
    end
  endtask

  // Monitor: compares every value change, done and err pulse with the scoreboard.
  always @(negedge clk) begin
    if (!rst_q) begin
      if (value !== prev_val) observe(K_VAL, int'(value), int'(owner));
      if (done === 1'b1)      observe(K_DONE, int'(value), int'(owner));
      if (err === 1'b1)       observe(K_ERR, int'(value), int'(owner));
    end
    prev_val = value;
  end

  // Call at a falling edge; returns the cycle index of the accepting edge.
  task automatic issue(input int ch, input int pos, output int acc);
    if (ch == 0) begin cmd0_valid = 1'b1; cmd0_pos = 3'(pos); end
    else         begin cmd1_valid = 1'b1; cmd1_pos = 3'(pos); end
    #1;
    chk(ch == 0 ? "ready0_idle" : "ready1_idle", ch == 0 ? int'(cmd0_ready) : int'(cmd1_ready), 1);
    @(posedge clk); #1;
    acc = cyc;
    cmd0_valid = 1'b0;
    cmd1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a, b;
    // Reset: readys low while rst is high, then all outputs at reset values.
    repeat (3) @(negedge clk);
    cmd0_valid = 1'b1; cmd0_pos = 3'd2;
    #1;
    chk("ready0_in_reset", int'(cmd0_ready), 0);
    chk("ready1_in_reset", int'(cmd1_ready), 0);
    cmd0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_value", int'(value), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);

    // Cold start: 0 -> 2 on the first cycle after reset.
    issue(0, 2, a);
    chk("busy_after_accept", int'(busy), 1);
    expect_ev(K_VAL, 2, 0, a + 4);
    expect_ev(K_DONE, 2, 0, a + 7);
    drain();
    chk("idle_after_done_busy", int'(busy), 0);

    // Up-ramp 2 -> 5.
    issue(0, 5, a);
    expect_ev(K_VAL, 3, 0, a + 4);
    expect_ev(K_VAL, 4, 0, a + 8);
    expect_ev(K_VAL, 5, 0, a + 12);
    expect_ev(K_DONE, 5, 0, a + 15);
    drain();

    // Down-ramp 5 -> 1 from the low-priority requester.
    issue(1, 1, a);
    expect_ev(K_VAL, 4, 1, a + 4);
    expect_ev(K_VAL, 3, 1, a + 8);
    expect_ev(K_VAL, 2, 1, a + 12);
    expect_ev(K_VAL, 1, 1, a + 16);
    expect_ev(K_DONE, 1, 1, a + 19);
    drain();
    chk("owner_after_ramp", int'(owner), 1);

    // Illegal code: err pulse, nothing else changes, next command taken at once.
    issue(0, 7, a);
    chk("busy_after_illegal", int'(busy), 0);
    expect_ev(K_ERR, 1, 1, a);
    @(negedge clk);
    issue(0, 3, b);
    chk("accept_after_illegal", b, a + 1);
    expect_ev(K_VAL, 2, 0, b + 4);
    expect_ev(K_VAL, 3, 0, b + 8);
    expect_ev(K_DONE, 3, 0, b + 11);
    drain();

    // Same target: one step period with no value change, then settle.
    issue(0, 3, a);
    expect_ev(K_DONE, 3, 0, a + 7);
    drain();
    chk("value_same_target", int'(value), 3);

    // Contention: requester 0 wins; requester 1 holds valid until after done.
    cmd0_valid = 1'b1; cmd0_pos = 3'd4;
    cmd1_valid = 1'b1; cmd1_pos = 3'd1;
    #1;
    chk("contention_ready0", int'(cmd0_ready), 1);
    chk("contention_ready1", int'(cmd1_ready), 0);
    @(posedge clk); #1;
    a = cyc;
    cmd0_valid = 1'b0;
    expect_ev(K_VAL, 4, 0, a + 4);
    expect_ev(K_DONE, 4, 0, a + 7);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd1_ready) break;
    end
    @(posedge clk); #1;
    b = cyc;
    cmd1_valid = 1'b0;
    chk("cmd1_accept_cycle", b, a + 8);
    expect_ev(K_VAL, 3, 1, b + 4);
    expect_ev(K_VAL, 2, 1, b + 8);
    expect_ev(K_VAL, 1, 1, b + 12);
    expect_ev(K_DONE, 1, 1, b + 15);
    drain();

    // Abort: reset two cycles after the first step of a 1 -> 5 move.
    issue(0, 5, a);
    expect_ev(K_VAL, 2, 0, a + 4);
    while (cyc < a + 5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_value", int'(value), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready0", int'(cmd0_ready), 0);
    chk("abort_scoreboard", q.size(), 0);
    rst = 1'b0;
    @(negedge clk);
    issue(1, 3, a);
    expect_ev(K_VAL, 3, 1, a + 4);
    expect_ev(K_DONE, 3, 1, a + 7);
    drain();

    repeat (5) @(negedge clk);
    chk("final_scoreboard", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
